// File: rtl/mips_interlock_ctrl.sv
// mips_interlock_ctrl: interlock and sequencing controller for the
// non-forwarding 5-stage MIPS-lite pipeline. Tracks destination registers
// in EX/MEM/WB, stalls IF/ID on RAW hazards, bubbles ID/EX, flushes on taken
// branches and drains/freezes the pipeline on HALT.
// Build option: define MIPS_INTERLOCK_STATS_EN to implement the stall/hazard
// statistic counters; otherwise stall_cnt and hazard_cnt read as zero.
module mips_interlock_ctrl #(
   parameter int unsigned REG_WIDTH = 5,
   parameter int unsigned CNT_W     = 32,
   parameter bit          WB_SPLIT  = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 id_valid,
   input  logic [REG_WIDTH-1:0] id_rs,
   input  logic [REG_WIDTH-1:0] id_rt,
   input  logic                 id_use_rs,
   input  logic                 id_use_rt,
   input  logic                 id_wr_en,
   input  logic [REG_WIDTH-1:0] id_rd,
   input  logic                 id_halt,
   input  logic                 ex_br_taken,
   output logic                 pc_hold,
   output logic                 idex_bubble,
   output logic                 ifid_flush,
   output logic                 halted,
   output logic [CNT_W-1:0]     stall_cnt,
   output logic [CNT_W-1:0]     hazard_cnt
);

   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

   state_t               state, stateNxt;
   logic [1:0]           drainCnt, drainNxt;
   logic                 sbExV, sbMemV, sbWbV;
   logic [REG_WIDTH-1:0] sbExRd, sbMemRd, sbWbRd;
   logic                 matchEx, matchMem, matchWb;
   logic                 raw, exLoad;

   // Register 0 is never loaded into the scoreboard, so it can never match.
   assign matchEx  = sbExV  & ((id_use_rs & (id_rs == sbExRd))  | (id_use_rt & (id_rt == sbExRd)));
   assign matchMem = sbMemV & ((id_use_rs & (id_rs == sbMemRd)) | (id_use_rt & (id_rt == sbMemRd)));
   assign matchWb  = sbWbV  & ((id_use_rs & (id_rs == sbWbRd))  | (id_use_rt & (id_rt == sbWbRd)));

   assign raw = id_valid & (state == RUN) & (matchEx | matchMem | (~WB_SPLIT & matchWb));

   assign exLoad = id_valid & id_wr_en & (id_rd != '0) & ~raw & ~ex_br_taken & (state == RUN);

   // Scoreboard shift and FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sbExV    <= 1'b0;
         sbMemV   <= 1'b0;
         sbWbV    <= 1'b0;
         sbExRd   <= '0;
         sbMemRd  <= '0;
         sbWbRd   <= '0;
         state    <= RUN;
         drainCnt <= '0;
      end else begin
         sbExV    <= exLoad;
         sbExRd   <= id_rd;
         sbMemV   <= sbExV;
         sbMemRd  <= sbExRd;
         sbWbV    <= sbMemV;
         sbWbRd   <= sbMemRd;
         state    <= stateNxt;
         drainCnt <= drainNxt;
      end
   end

   // Next-state and pipeline control outputs
   always_comb begin
      stateNxt    = state;
      drainNxt    = drainCnt;
      pc_hold     = 1'b0;
      idex_bubble = 1'b0;
      ifid_flush  = 1'b0;
      halted      = 1'b0;
      case (state)
         RUN: begin
            if (ex_br_taken) begin
               ifid_flush  = 1'b1;
               idex_bubble = 1'b1;
            end else if (raw) begin
               pc_hold     = 1'b1;
               idex_bubble = 1'b1;
            end
            if (id_valid && id_halt && !raw && !ex_br_taken) begin
               stateNxt = DRAIN;
               drainNxt = '0;
            end
         end
         DRAIN: begin
            pc_hold    = 1'b1;
            ifid_flush = 1'b1;
            drainNxt   = drainCnt + 2'd1;
            // Count reaches 3 on this edge: HALT has just left WB.
            if (drainCnt == 2'd2) stateNxt = HALTED;
         end
         HALTED: begin
            pc_hold     = 1'b1;
            idex_bubble = 1'b1;
            halted      = 1'b1;
         end
         default: stateNxt = RUN;
      endcase
   end

`ifdef MIPS_INTERLOCK_STATS_EN
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic             rawQ, stallEvt, hazardEvt;
   logic [CNT_W-1:0] stallCnt, hazardCnt;

   // A taken branch overrides the stall, so it neither counts nor arms rawQ.
   assign stallEvt  = raw & ~ex_br_taken;
   assign hazardEvt = stallEvt & ~rawQ;

   // Saturating statistic counters
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rawQ      <= 1'b0;
         stallCnt  <= '0;
         hazardCnt <= '0;
      end else begin
         rawQ <= stallEvt;
         if (stallEvt && (stallCnt != '1)) stallCnt <= stallCnt + CNT_ONE;
         if (hazardEvt && (hazardCnt != '1)) hazardCnt <= hazardCnt + CNT_ONE;
      end
   end

   assign stall_cnt  = stallCnt;
   assign hazard_cnt = hazardCnt;
`else
   assign stall_cnt  = '0;
   assign hazard_cnt = '0;
`endif

endmodule
